// File: rtl/punc_controller.sv
// punc_controller: multi-cycle fetch/decode/execute sequencer for the PUnC
// LC3 datapath. Every datapath strobe and select is a combinational decode
// of the current state and the instruction register contents. The block also
// reports halt status and counts retired instructions.
module punc_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ir,
  input  logic             nzp_true,
  output logic             pc_ld,
  output logic             pc_clr,
  output logic             pc_inc,
  output logic [1:0]       pc_sel,
  output logic             ir_ld,
  output logic             ir_clr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [1:0]       mem_r_addr_sel,
  output logic [1:0]       mem_w_addr_sel,
  output logic [1:0]       rf_w_data_sel,
  output logic             rf_w_addr_sel,
  output logic             rf_w_wr,
  output logic             rf_rp_addr_sel,
  output logic             rf_rp_rd,
  output logic             rf_rq_rd,
  output logic             temp_ld,
  output logic             nzp_ld,
  output logic             nzp_clr,
  output logic [1:0]       alu_sel,
  output logic             alu_first_val_sel,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_INIT, S_FETCH, S_DECODE, S_EXEC, S_EXEC2, S_HALT
  } state_t;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  state_t     state;
  logic [3:0] opcode;
  logic       two_cycle;
  logic       unused_ir;

  assign opcode    = ir[15:12];
  assign two_cycle = (opcode == OP_LDI) || (opcode == OP_STI);
  // Register fields are steered by the datapath; only the opcode and a few
  // mode bits matter to the sequencer.
  assign unused_ir = ^{ir[10:6], ir[4:0]};

  // State sequencing and retired-instruction counting.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_INIT;
      instr_cnt <= '0;
    end else begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          if (opcode == OP_TRAP) begin
            state     <= S_HALT;
            instr_cnt <= instr_cnt + CNT_W'(1);
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (two_cycle) begin
            state <= S_EXEC2;
          end else begin
            state     <= S_FETCH;
            instr_cnt <= instr_cnt + CNT_W'(1);
          end
        end
        S_EXEC2: begin
          state     <= S_FETCH;
          instr_cnt <= instr_cnt + CNT_W'(1);
        end
        S_HALT:   state <= S_HALT;
        default:  state <= S_INIT;
      endcase
    end
  end

  // Datapath control decode from state and opcode.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // statements can leave a value held, which would infer a latch.
    pc_ld             = 1'b0;
    pc_clr            = 1'b0;
    pc_inc            = 1'b0;
    pc_sel            = 2'd0;
    ir_ld             = 1'b0;
    ir_clr            = 1'b0;
    mem_rd            = 1'b0;
    mem_wr            = 1'b0;
    mem_r_addr_sel    = 2'd0;
    mem_w_addr_sel    = 2'd0;
    rf_w_data_sel     = 2'd0;
    rf_w_addr_sel     = 1'b0;
    rf_w_wr           = 1'b0;
    rf_rp_addr_sel    = 1'b0;
    rf_rp_rd          = 1'b0;
    rf_rq_rd          = 1'b0;
    temp_ld           = 1'b0;
    nzp_ld            = 1'b0;
    nzp_clr           = 1'b0;
    alu_sel           = 2'd0;
    alu_first_val_sel = 1'b0;
    halted            = 1'b0;

    case (state)
      S_INIT: begin
        pc_clr  = 1'b1;
        ir_clr  = 1'b1;
        nzp_clr = 1'b1;
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
      end
      S_EXEC: begin
        case (opcode)
          OP_ADD, OP_AND: begin
            rf_rp_rd          = 1'b1;
            rf_rq_rd          = 1'b1;
            alu_sel           = (opcode == OP_AND) ? 2'd1 : 2'd0;
            alu_first_val_sel = ir[5];
            rf_w_wr           = 1'b1;
            nzp_ld            = 1'b1;
          end
          OP_NOT: begin
            rf_rp_rd = 1'b1;
            alu_sel  = 2'd2;
            rf_w_wr  = 1'b1;
            nzp_ld   = 1'b1;
          end
          OP_BR: pc_ld = nzp_true;
          OP_JMP: begin
            rf_rp_rd = 1'b1;
            pc_sel   = 2'd2;
            pc_ld    = 1'b1;
          end
          OP_JSR: begin
            // R7 captures the current PC on the same edge the PC jumps, so
            // JSRR R7 still targets the old R7 value.
            rf_w_wr       = 1'b1;
            rf_w_addr_sel = 1'b1;
            rf_w_data_sel = 2'd3;
            pc_ld         = 1'b1;
            pc_sel        = ir[11] ? 2'd1 : 2'd2;
            rf_rp_rd      = ~ir[11];
          end
          OP_LD: begin
            mem_rd         = 1'b1;
            mem_r_addr_sel = 2'd1;
            rf_w_wr        = 1'b1;
            rf_w_data_sel  = 2'd1;
            nzp_ld         = 1'b1;
          end
          OP_LDR: begin
            mem_rd         = 1'b1;
            mem_r_addr_sel = 2'd2;
            rf_rp_rd       = 1'b1;
            rf_w_wr        = 1'b1;
            rf_w_data_sel  = 2'd1;
            nzp_ld         = 1'b1;
          end
          OP_LEA: begin
            rf_w_wr       = 1'b1;
            rf_w_data_sel = 2'd2;
          end
          OP_ST: begin
            rf_rp_addr_sel = 1'b1;
            rf_rp_rd       = 1'b1;
            mem_wr         = 1'b1;
            mem_w_addr_sel = 2'd0;
          end
          OP_STR: begin
            // Single port carries both base and data: the stored value is
            // the base register itself, addressed at base + sext6.
            rf_rp_addr_sel = 1'b0;
            rf_rp_rd       = 1'b1;
            mem_wr         = 1'b1;
            mem_w_addr_sel = 2'd1;
          end
          OP_LDI, OP_STI: begin
            mem_rd         = 1'b1;
            mem_r_addr_sel = 2'd1;
            temp_ld        = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        if (opcode == OP_LDI) begin
          mem_rd         = 1'b1;
          mem_r_addr_sel = 2'd3;
          rf_w_wr        = 1'b1;
          rf_w_data_sel  = 2'd1;
          nzp_ld         = 1'b1;
        end else begin
          rf_rp_addr_sel = 1'b1;
          rf_rp_rd       = 1'b1;
          mem_wr         = 1'b1;
          mem_w_addr_sel = 2'd2;
        end
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_punc_controller.sv
// Table-driven bench for punc_controller: each record gives an instruction,
// the branch flag and the hand-derived control word for EXEC (and EXEC2).
// A narrow counter makes the retired-count wrap visible in a short run.
module tb_punc_controller;

  localparam int CNT_W = 4;

  typedef struct packed {
    logic       pc_ld;
    logic       pc_clr;
    logic       pc_inc;
    logic [1:0] pc_sel;
    logic       ir_ld;
    logic       ir_clr;
    logic       mem_rd;
    logic       mem_wr;
    logic [1:0] mem_r_addr_sel;
    logic [1:0] mem_w_addr_sel;
    logic [1:0] rf_w_data_sel;
    logic       rf_w_addr_sel;
    logic       rf_w_wr;
    logic       rf_rp_addr_sel;
    logic       rf_rp_rd;
    logic       rf_rq_rd;
    logic       temp_ld;
    logic       nzp_ld;
    logic       nzp_clr;
    logic [1:0] alu_sel;
    logic       alu_first_val_sel;
    logic       halted;
  } ctl_t;

  typedef struct {
    logic [15:0] ir;
    logic        nzp;
    logic        two;
    ctl_t        exp;
    ctl_t        exp2;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [15:0] ir = '0;
  logic nzp_true = 1'b0;
  logic pc_ld, pc_clr, pc_inc, ir_ld, ir_clr, mem_rd, mem_wr;
  logic [1:0] pc_sel, mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, alu_sel;
  logic rf_w_addr_sel, rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd;
  logic temp_ld, nzp_ld, nzp_clr, alu_first_val_sel, halted;
  logic [CNT_W-1:0] instr_cnt;

  ctl_t act;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  vec_t vecs[$];

  punc_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ir(ir), .nzp_true(nzp_true),
    .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_sel(pc_sel),
    .ir_ld(ir_ld), .ir_clr(ir_clr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_r_addr_sel(mem_r_addr_sel), .mem_w_addr_sel(mem_w_addr_sel),
    .rf_w_data_sel(rf_w_data_sel), .rf_w_addr_sel(rf_w_addr_sel),
    .rf_w_wr(rf_w_wr), .rf_rp_addr_sel(rf_rp_addr_sel),
    .rf_rp_rd(rf_rp_rd), .rf_rq_rd(rf_rq_rd), .temp_ld(temp_ld),
    .nzp_ld(nzp_ld), .nzp_clr(nzp_clr), .alu_sel(alu_sel),
    .alu_first_val_sel(alu_first_val_sel), .halted(halted),
    .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  assign act = {pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr, mem_rd, mem_wr,
                mem_r_addr_sel, mem_w_addr_sel, rf_w_data_sel, rf_w_addr_sel,
                rf_w_wr, rf_rp_addr_sel, rf_rp_rd, rf_rq_rd, temp_ld, nzp_ld,
                nzp_clr, alu_sel, alu_first_val_sel, halted};

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
  endtask

  task automatic add(input logic [15:0] i, input logic n, input logic t,
                     input ctl_t e, input ctl_t e2);
    vec_t v;
    v.ir = i; v.nzp = n; v.two = t; v.exp = e; v.exp2 = e2;
    vecs.push_back(v);
  endtask

  localparam ctl_t Z       = '0;
  localparam ctl_t C_CLR   = ctl_t'{pc_clr:1'b1, ir_clr:1'b1, nzp_clr:1'b1, default:'0};
  localparam ctl_t C_FETCH = ctl_t'{mem_rd:1'b1, ir_ld:1'b1, pc_inc:1'b1, default:'0};
  localparam ctl_t C_HALT  = ctl_t'{halted:1'b1, default:'0};

  initial begin
    add(16'h1261, 0, 0, ctl_t'{rf_rp_rd:1'b1, rf_rq_rd:1'b1, alu_first_val_sel:1'b1,
        rf_w_wr:1'b1, nzp_ld:1'b1, default:'0}, Z);                       // ADD imm
    add(16'h5042, 0, 0, ctl_t'{rf_rp_rd:1'b1, rf_rq_rd:1'b1, alu_sel:2'd1,
        rf_w_wr:1'b1, nzp_ld:1'b1, default:'0}, Z);                       // AND reg
    add(16'h927F, 0, 0, ctl_t'{rf_rp_rd:1'b1, alu_sel:2'd2, rf_w_wr:1'b1,
        nzp_ld:1'b1, default:'0}, Z);                                     // NOT
    add(16'h0402, 0, 0, Z, Z);                                            // BRz not taken
    add(16'h0402, 1, 0, ctl_t'{pc_ld:1'b1, default:'0}, Z);               // BRz taken
    add(16'hC1C0, 0, 0, ctl_t'{rf_rp_rd:1'b1, pc_sel:2'd2, pc_ld:1'b1, default:'0}, Z);
    add(16'h4803, 0, 0, ctl_t'{rf_w_wr:1'b1, rf_w_addr_sel:1'b1, rf_w_data_sel:2'd3,
        pc_ld:1'b1, pc_sel:2'd1, default:'0}, Z);                         // JSR
    add(16'h41C0, 0, 0, ctl_t'{rf_w_wr:1'b1, rf_w_addr_sel:1'b1, rf_w_data_sel:2'd3,
        pc_ld:1'b1, pc_sel:2'd2, rf_rp_rd:1'b1, default:'0}, Z);          // JSRR R7
    add(16'h2205, 0, 0, ctl_t'{mem_rd:1'b1, mem_r_addr_sel:2'd1, rf_w_wr:1'b1,
        rf_w_data_sel:2'd1, nzp_ld:1'b1, default:'0}, Z);                 // LD
    add(16'h6281, 0, 0, ctl_t'{mem_rd:1'b1, mem_r_addr_sel:2'd2, rf_rp_rd:1'b1,
        rf_w_wr:1'b1, rf_w_data_sel:2'd1, nzp_ld:1'b1, default:'0}, Z);   // LDR
    add(16'hE3FF, 0, 0, ctl_t'{rf_w_wr:1'b1, rf_w_data_sel:2'd2, default:'0}, Z);
    add(16'h3405, 0, 0, ctl_t'{rf_rp_addr_sel:1'b1, rf_rp_rd:1'b1, mem_wr:1'b1,
        default:'0}, Z);                                                  // ST
    add(16'h7443, 0, 0, ctl_t'{rf_rp_rd:1'b1, mem_wr:1'b1, mem_w_addr_sel:2'd1,
        default:'0}, Z);                                                  // STR
    add(16'h8000, 0, 0, Z, Z);                                            // RTI as NOP
    add(16'hD000, 1, 0, Z, Z);                                            // reserved
    add(16'hA005, 0, 1, ctl_t'{mem_rd:1'b1, mem_r_addr_sel:2'd1, temp_ld:1'b1, default:'0},
        ctl_t'{mem_rd:1'b1, mem_r_addr_sel:2'd3, rf_w_wr:1'b1, rf_w_data_sel:2'd1,
        nzp_ld:1'b1, default:'0});                                        // LDI
    add(16'hB205, 0, 1, ctl_t'{mem_rd:1'b1, mem_r_addr_sel:2'd1, temp_ld:1'b1, default:'0},
        ctl_t'{rf_rp_addr_sel:1'b1, rf_rp_rd:1'b1, mem_wr:1'b1, mem_w_addr_sel:2'd2,
        default:'0});                                                     // STI

    // Reset held for two cycles: clears asserted, counter zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset clears", act, C_CLR);
    check("reset cnt", 32'(instr_cnt), 0);
    rst = 1'b1;
    #1 check("init clears", act, C_CLR);
    @(negedge clk);

    // 17 instructions wrap the 4-bit counter back through zero.
    foreach (vecs[i]) begin
      check($sformatf("fetch %0d", i), act, C_FETCH);
      ir = vecs[i].ir;
      nzp_true = vecs[i].nzp;
      @(negedge clk);
      check($sformatf("decode %0d", i), act, Z);
      @(negedge clk);
      check($sformatf("exec %0h", vecs[i].ir), act, vecs[i].exp);
      if (vecs[i].two) begin
        @(negedge clk);
        check($sformatf("exec2 %0h", vecs[i].ir), act, vecs[i].exp2);
      end
      @(negedge clk);
      exp_cnt = exp_cnt + 1'b1;
      check($sformatf("cnt after %0h", vecs[i].ir), 32'(instr_cnt), 32'(exp_cnt));
    end
    nzp_true = 1'b0;

    // TRAP: halt after DECODE, counted once, quiet for 20 cycles.
    check("fetch trap", act, C_FETCH);
    ir = 16'hF025;
    @(negedge clk);
    check("decode trap", act, Z);
    @(negedge clk);
    exp_cnt = exp_cnt + 1'b1;
    check("halt entry", act, C_HALT);
    check("halt cnt", 32'(instr_cnt), 32'(exp_cnt));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check($sformatf("halt hold %0d", k), act, C_HALT);
      check($sformatf("halt cnt %0d", k), 32'(instr_cnt), 32'(exp_cnt));
    end

    // Asynchronous reset mid-HALT, away from any clock edge.
    #2 rst = 1'b0;
    #1 check("async halted", 32'(halted), 0);
    check("async cnt", 32'(instr_cnt), 0);
    check("async clears", act, C_CLR);

    // Abort an LDI in its EXEC cycle: strobes drop immediately.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("refetch", act, C_FETCH);
    ir = 16'hA005;
    @(negedge clk);
    @(negedge clk);
    check("ldi exec pre-abort", 32'(temp_ld), 1);
    #2 rst = 1'b0;
    #1 check("abort strobes", act, C_CLR);
    check("abort cnt", 32'(instr_cnt), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
